p0_capture_fifo: RTL

//   Downstream consumer of the microcontroller's port-0 output (p0_data_out).

---
 rtl/p0_capture_fifo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/p0_capture_fifo.sv
// ---------------------------------------------------------------------------
// p0_capture_fifo
//
// Purpose:
//   Watches the microcontroller's 16-bit port-0 output. Every time the value
//   changes, the new value is queued in a small first-word-fall-through FIFO.
//   A slow sink drains the FIFO over a valid/ready handshake, so it never
//   misses a port-0 update unless the queue is already full.
//
// Ports:
//   clk         in   1         system clock, rising edge
//   rst         in   1         synchronous active-high reset
//   p0_data_in  in   DATA_W    port-0 value being monitored
//   out_data    out  DATA_W    head-of-queue value (0 when empty)
//   out_valid   out  1         queue not empty
//   out_ready   in   1         sink takes the head this cycle
//   count       out  ADDR_W+1  occupancy, 0..DEPTH
//   full        out  1         count == DEPTH
//   overflow    out  1         sticky: a change was dropped while full
//   ovf_clr     in   1         clears overflow (a same-edge drop wins)
//   drop_count  out  16        only with P0_DROP_CNT_EN: saturating drop tally
//
// Configuration:
//   `define P0_DROP_CNT_EN to add the drop_count output and its counter.
// ---------------------------------------------------------------------------
module p0_capture_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] p0_data_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
`ifdef P0_DROP_CNT_EN
    output logic [15:0]       drop_count,
`endif
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0] DepthVal = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              baseVld_q, baseVld_d;

    logic push;
    logic pop;
    logic writeEn;
    logic drop;

    // Handshake and change detection. The first edge after reset only
    // captures a baseline value, so nothing can be pushed until baseVld_q.
    // When full, a push still succeeds if the head leaves on the same edge,
    // because that pop frees the slot being written.
    always_comb begin
        out_valid = (count_q != '0);
        full      = (count_q == DepthVal);
        out_data  = out_valid ? mem[rdPtr_q] : '0;
        count     = count_q;
        overflow  = overflow_q;
        push      = baseVld_q && (p0_data_in != prev_q);
        pop       = out_valid && out_ready;
        writeEn   = push && (!full || pop);
        drop      = push && full && !pop;
    end

    // Next-state computation for pointers, occupancy, the sticky overflow
    // flag and the change-detect history.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        prev_d     = p0_data_in;
        baseVld_d  = 1'b1;

        if (writeEn) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end

        if (writeEn && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !writeEn) begin
            count_d = count_q - 1'b1;
        end

        // A drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Control state registers; reset overrides every other activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            prev_q     <= '0;
            baseVld_q  <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            prev_q     <= prev_d;
            baseVld_q  <= baseVld_d;
        end
    end

    // Storage array. Contents need no reset: out_data is forced to zero
    // whenever the queue is empty, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (!rst && writeEn) begin
            mem[wrPtr_q] <= p0_data_in;
        end
    end

`ifdef P0_DROP_CNT_EN
    logic [15:0] dropCount_q, dropCount_d;

    // Saturating drop tally. A clear on the same edge as a drop restarts the
    // count at one so that drop is not lost.
    always_comb begin
        dropCount_d = dropCount_q;
        if (ovf_clr) begin
            dropCount_d = drop ? 16'd1 : 16'd0;
        end else if (drop && dropCount_q != 16'hFFFF) begin
            dropCount_d = dropCount_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dropCount_q <= '0;
        end else begin
            dropCount_q <= dropCount_d;
        end
    end

    assign drop_count = dropCount_q;
`endif

endmodule
